// File: rtl/from_serial.sv
// Per-channel serial-to-parallel reassembly: LSB-first chunks are collected into BW_OUT-bit words.
// Optional mid-word gap detection (sticky err) is enabled with FROM_SERIAL_GAP_CHECK_EN.
module from_serial #(
   parameter int NO_CH  = 64,
   parameter int BW_IN  = 4,
   parameter int BW_OUT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      vld_in,
   input  logic                      align,
   input  logic [NO_CH*BW_IN-1:0]    data_in,
   output logic                      vld_out,
   output logic [NO_CH*BW_OUT-1:0]   data_out,
   output logic                      err
);

   localparam int SER_CYC = BW_OUT / BW_IN;

   if ((BW_OUT % BW_IN) != 0 || SER_CYC < 1 || (SER_CYC & (SER_CYC - 1)) != 0) begin : g_bad_cfg
      $error("from_serial: BW_OUT must be a power-of-two multiple of BW_IN");
   end

   if (SER_CYC == 1) begin : g_passthru
      // Every chunk is a whole word, so there is nothing to count, align or frame.
      logic unused_align;
      assign unused_align = align;
      assign err          = 1'b0;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_out  <= 1'b0;
            data_out <= '0;
         end else begin
            vld_out <= vld_in;
            if (vld_in)
               data_out <= data_in;
         end
      end
   end else begin : g_deser
      localparam int              CNT_W = $clog2(SER_CYC);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(SER_CYC - 1);

      logic [CNT_W-1:0]          cnt;
      logic [NO_CH*BW_OUT-1:0]   shreg;
      logic [NO_CH*BW_OUT-1:0]   shreg_nxt;

      // New chunk enters at the top and older chunks move down, so after SER_CYC
      // shifts chunk 0 sits in the LSBs. Stale partial data is always shifted out.
      always_comb begin
         // NOTE: combinational outputs get a default first so no path can infer a latch.
         shreg_nxt = '0;
         for (int i = 0; i < NO_CH; i++)
            shreg_nxt[i*BW_OUT +: BW_OUT] = {data_in[i*BW_IN +: BW_IN],
                                             shreg[i*BW_OUT+BW_IN +: BW_OUT-BW_IN]};
      end

`ifdef FROM_SERIAL_GAP_CHECK_EN
      logic err_q;
      assign err = err_q;
`else
      assign err = 1'b0;
`endif

      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt      <= '0;
            shreg    <= '0;
            data_out <= '0;
            vld_out  <= 1'b0;
`ifdef FROM_SERIAL_GAP_CHECK_EN
            err_q    <= 1'b0;
`endif
         end else begin
            vld_out <= 1'b0;
            if (align) begin
               // Restart framing; a chunk arriving with align becomes chunk 0, even if
               // it would otherwise have been the final chunk of the discarded word.
               cnt <= vld_in ? CNT_W'(1) : '0;
               if (vld_in)
                  shreg <= shreg_nxt;
            end else if (vld_in) begin
               shreg <= shreg_nxt;
               if (cnt == LAST) begin
                  cnt      <= '0;
                  data_out <= shreg_nxt;
                  vld_out  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef FROM_SERIAL_GAP_CHECK_EN
            else if (cnt != '0) begin
               err_q <= 1'b1;
               cnt   <= '0;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_from_serial.sv
// Randomised and directed bench for from_serial (2 x 4-bit -> 16-bit, plus a 16->16 pass-through).
// A queue-based chunk model predicts vld_out/data_out/err; build with FROM_SERIAL_GAP_CHECK_EN to test gap checking.
module tb_from_serial;

   localparam bit GAP =
`ifdef FROM_SERIAL_GAP_CHECK_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld_in = 1'b0, align = 1'b0;
   logic [7:0]  data_in = '0;
   logic        vld_out, err;
   logic [31:0] data_out;

   logic        vld1 = 1'b0, align1 = 1'b0;
   logic [15:0] data1 = '0;
   logic        vld_out1, err1;
   logic [15:0] data_out1;

   int total = 0;
   int bad   = 0;

   // Reference model: chunks received so far in the current word, per channel.
   logic [3:0]  q0[$], q1[$];
   logic        exp_vld = 1'b0, exp_err = 1'b0;
   logic [15:0] exp_d0 = '0, exp_d1 = '0;

   always #5 clk = ~clk;

   from_serial #(.NO_CH(2), .BW_IN(4), .BW_OUT(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .align(align), .data_in(data_in),
      .vld_out(vld_out), .data_out(data_out), .err(err)
   );

   from_serial #(.NO_CH(1), .BW_IN(16), .BW_OUT(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .vld_in(vld1), .align(align1), .data_in(data1),
      .vld_out(vld_out1), .data_out(data_out1), .err(err1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_vld"}, {31'd0, vld_out}, {31'd0, exp_vld});
      chk({tag, "_ch0"}, {16'd0, data_out[15:0]}, {16'd0, exp_d0});
      chk({tag, "_ch1"}, {16'd0, data_out[31:16]}, {16'd0, exp_d1});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
   endtask

   task automatic model_reset();
      q0.delete(); q1.delete();
      exp_vld = 1'b0; exp_err = 1'b0; exp_d0 = '0; exp_d1 = '0;
   endtask

   // One clock with the given inputs; the model then states what the outputs must be after the edge.
   task automatic step(input string tag, input logic v, input logic a,
                       input logic [3:0] c0, input logic [3:0] c1);
      @(negedge clk);
      vld_in = v; align = a; data_in = {c1, c0};
      @(posedge clk);
      #1;
      exp_vld = 1'b0;
      if (a) begin
         q0.delete(); q1.delete();
         if (v) begin q0.push_back(c0); q1.push_back(c1); end
      end else if (v) begin
         q0.push_back(c0); q1.push_back(c1);
         if (q0.size() == 4) begin
            exp_d0 = '0; exp_d1 = '0;
            for (int k = 0; k < 4; k++) begin
               exp_d0 = exp_d0 + (16'(q0[k]) << (4 * k));
               exp_d1 = exp_d1 + (16'(q1[k]) << (4 * k));
            end
            exp_vld = 1'b1;
            q0.delete(); q1.delete();
         end
      end else if (GAP && q0.size() != 0) begin
         exp_err = 1'b1;
         q0.delete(); q1.delete();
      end
      check_model(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   initial begin
      // Reset state (asynchronous, before any clock edge)
      #2;
      check_model("rst");
      chk("rst_dut1_vld", {31'd0, vld_out1}, 32'd0);
      chk("rst_dut1_data", {16'd0, data_out1}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Four chunks on both channels -> one word pair
      step("w1_c0", 1'b1, 1'b0, 4'h1, 4'hA);
      step("w1_c1", 1'b1, 1'b0, 4'h2, 4'hB);
      step("w1_c2", 1'b1, 1'b0, 4'h3, 4'hC);
      step("w1_c3", 1'b1, 1'b0, 4'h4, 4'hD);
      chk("w1_const_vld", {31'd0, vld_out}, 32'd1);
      chk("w1_const_ch0", {16'd0, data_out[15:0]}, 32'h4321);
      chk("w1_const_ch1", {16'd0, data_out[31:16]}, 32'hDCBA);
      idle("w1_hold");

      // Back-to-back words, no bubble
      for (int i = 1; i <= 8; i++) begin
         step("b2b", 1'b1, 1'b0, 4'(i), 4'(i + 8));
         if (i == 4) chk("b2b_const_w0", {16'd0, data_out[15:0]}, 32'h4321);
         if (i == 8) chk("b2b_const_w1", {16'd0, data_out[15:0]}, 32'h8765);
      end
      idle("b2b_hold");

      // Align discards a partial word
      step("al_c0", 1'b1, 1'b0, 4'h1, 4'h1);
      step("al_c1", 1'b1, 1'b0, 4'h2, 4'h2);
      step("al_pulse", 1'b0, 1'b1, 4'h0, 4'h0);
      for (int i = 5; i <= 8; i++) step("al_word", 1'b1, 1'b0, 4'(i), 4'(i));
      chk("al_const_ch0", {16'd0, data_out[15:0]}, 32'h8765);

      // Align together with the final chunk: no pulse, that chunk restarts the word
      step("alf_c0", 1'b1, 1'b0, 4'h1, 4'h0);
      step("alf_c1", 1'b1, 1'b0, 4'h2, 4'h0);
      step("alf_c2", 1'b1, 1'b0, 4'h3, 4'h0);
      step("alf_c3", 1'b1, 1'b1, 4'h4, 4'h0);
      chk("alf_no_vld", {31'd0, vld_out}, 32'd0);
      for (int i = 5; i <= 7; i++) step("alf_word", 1'b1, 1'b0, 4'(i), 4'h0);
      chk("alf_const_ch0", {16'd0, data_out[15:0]}, 32'h7654);

      // Reset mid-word
      step("rw_c0", 1'b1, 1'b0, 4'h7, 4'h7);
      step("rw_c1", 1'b1, 1'b0, 4'h7, 4'h7);
      @(negedge clk);
      rst_n = 1'b0; vld_in = 1'b0; align = 1'b0;
      #1;
      model_reset();
      check_model("rw_in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 9; i <= 12; i++) step("rw_word", 1'b1, 1'b0, 4'(i), 4'(i));
      chk("rw_const_ch0", {16'd0, data_out[15:0]}, 32'hCBA9);
      idle("rw_hold");

      // Mid-word gap: framing error with the check, tolerated without it
      step("gap_c0", 1'b1, 1'b0, 4'h1, 4'h1);
      step("gap_c1", 1'b1, 1'b0, 4'h2, 4'h2);
      idle("gap_idle");
      step("gap_c2", 1'b1, 1'b0, 4'h3, 4'h3);
      if (GAP) begin
         chk("gap_err_set", {31'd0, err}, 32'd1);
         idle("gap_idle2");
         for (int i = 1; i <= 4; i++) step("gap_re", 1'b1, 1'b0, 4'(i), 4'(i));
         chk("gap_re_ch0", {16'd0, data_out[15:0]}, 32'h4321);
         chk("gap_err_sticky", {31'd0, err}, 32'd1);
      end else begin
         step("gap_c3", 1'b1, 1'b0, 4'h4, 4'h4);
         chk("gap_tol_ch0", {16'd0, data_out[15:0]}, 32'h4321);
         chk("gap_tol_err", {31'd0, err}, 32'd0);
      end

      // Randomised traffic with gaps and occasional align
      for (int i = 0; i < 400; i++)
         step("rnd", ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
              4'($urandom), 4'($urandom));

      // Pass-through configuration (one chunk per word)
      @(negedge clk);
      vld1 = 1'b1; data1 = 16'hBEEF; align1 = 1'b1;
      @(posedge clk); #1;
      chk("p1_vld", {31'd0, vld_out1}, 32'd1);
      chk("p1_data", {16'd0, data_out1}, 32'hBEEF);
      chk("p1_err", {31'd0, err1}, 32'd0);
      @(negedge clk);
      vld1 = 1'b0; data1 = 16'h1234; align1 = 1'b0;
      @(posedge clk); #1;
      chk("p1_pulse_end", {31'd0, vld_out1}, 32'd0);
      chk("p1_hold", {16'd0, data_out1}, 32'hBEEF);
      for (int i = 0; i < 20; i++) begin
         logic        v;
         logic [15:0] d, prev;
         v = 1'($urandom);
         d = 16'($urandom);
         prev = data_out1;
         @(negedge clk);
         vld1 = v; data1 = d;
         @(posedge clk); #1;
         chk("p1_rnd_vld", {31'd0, vld_out1}, {31'd0, v});
         chk("p1_rnd_data", {16'd0, data_out1}, {16'd0, v ? d : prev});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/from_serial.md
FROM_SERIAL -- requirements
Module: from_serial

Interface
REQ-001 SHALL have parameter NO_CH, default 64: number of independent channels.
REQ-002 SHALL have parameter BW_IN, default 4: serial chunk width per channel, in bits.
REQ-003 SHALL have parameter BW_OUT, default 16: reassembled word width per channel, in bits.
REQ-004 SHALL derive SER_CYC = BW_OUT/BW_IN; elaboration SHALL fail unless BW_OUT is a multiple of BW_IN and SER_CYC is a power of two.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port vld_in, input, 1 bit: data_in carries one chunk for every channel.
REQ-008 SHALL have port align, input, 1 bit: synchronous restart of chunk counting (pairs with the windower ser_rst).
REQ-009 SHALL have port data_in, input, NO_CH*BW_IN bits: channel i chunk at [i*BW_IN +: BW_IN].
REQ-010 SHALL have port vld_out, output, 1 bit: one-cycle pulse, data_out holds a new complete word set.
REQ-011 SHALL have port data_out, output, NO_CH*BW_OUT bits: channel i word at [i*BW_OUT +: BW_OUT].
REQ-012 SHALL have port err, output, 1 bit: sticky framing error (see Configuration).

Function
REQ-013 SHALL be the inverse of to_serial: chunks arrive LSB-first, with chunk k (k=0 first) placed at word bits [k*BW_IN +: BW_IN].
REQ-014 SHALL keep a log2(SER_CYC)-bit chunk counter that increments on each accepted vld_in and wraps from SER_CYC-1 to 0.
REQ-015 SHALL, on vld_in with counter = SER_CYC-1, register the completed word set into data_out and assert vld_out on the next cycle (latency 1 from the last chunk).
REQ-016 SHALL hold data_out stable between vld_out pulses; vld_out SHALL be high for exactly one cycle per completed word.
REQ-017 SHALL, on align high, clear the counter and discard partial chunks; align together with vld_in SHALL accept that chunk as chunk 0.
REQ-018 SHALL treat align during the final chunk as discarding it: no vld_out pulse results.
REQ-019 SHALL, when SER_CYC = 1, register data_in to data_out with vld_out = registered vld_in (latency 1).
REQ-020 SHALL allow vld_in gaps of any length between chunks; counter and partial data are held across gaps (without the macro).
REQ-021 SHALL sustain back-to-back words: one vld_out every SER_CYC consecutive vld_in cycles, with no bubble.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear the counter, the partial-word register, data_out (all zeros), vld_out (0) and err (0).
REQ-023 SHALL discard any partial word on reset mid-word; the first chunk after reset release is chunk 0.

Configuration
REQ-024 SHALL, with macro FROM_SERIAL_GAP_CHECK_EN defined, treat vld_in low while counter != 0 (mid-word gap) as a framing error: set err sticky, clear the counter, discard the partial word; err SHALL clear only on reset.
REQ-025 SHALL, without FROM_SERIAL_GAP_CHECK_EN, tie err to 0 and tolerate gaps per REQ-020.

Verification
REQ-026 NO_CH=2, BW_IN=4, BW_OUT=16; ch0 chunks 0x1,0x2,0x3,0x4 and ch1 chunks 0xA,0xB,0xC,0xD on 4 consecutive cycles -> one cycle later vld_out=1, ch0=0x4321, ch1=0xDCBA.
REQ-027 Same setup, 8 consecutive chunks 0x1..0x8 on ch0 -> vld_out pulses 4 cycles apart, ch0=0x4321 then 0x8765.
REQ-028 Two chunks sent, align pulsed, then 0x5,0x6,0x7,0x8 -> single vld_out, ch0=0x8765.
REQ-029 Two chunks sent, rst_n low for 1 cycle, then four chunks 0x9,0xA,0xB,0xC -> vld_out once with ch0=0xCBA9; data_out=0 during reset.
REQ-030 With gap check: chunks 0x1,0x2, one idle cycle, then 0x3 -> err=1, no vld_out; the next 4 chunks 0x1..0x4 -> ch0=0x4321, err stays 1. Without the macro, the same stimulus with a 4th chunk 0x4 -> ch0=0x4321, err=0.
REQ-031 SER_CYC=1 (BW_IN=BW_OUT=16): data_in 0xBEEF with vld_in -> next cycle vld_out=1, ch0=0xBEEF.
